// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock pushbutton conditioner:
// channel indices, repeat FSM states and default timing parameters.
package clock_pkg;

   localparam int BTN_STRTSTP    = 0;
   localparam int BTN_SET_TIME   = 1;
   localparam int BTN_STOP_WATCH = 2;
   localparam int BTN_SET_ALARM  = 3;

   localparam int DEF_DB_CYCLES  = 20;
   localparam int DEF_RPT_DELAY  = 500;
   localparam int DEF_RPT_PERIOD = 100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter width for a terminal count of n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clock_btn_cond_if.sv
// Button bundle between the board pins / control FSM and the conditioner.
interface clock_btn_cond_if #(
   parameter int NUM_BTN = 4
);
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_lvl;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_rpt;

   modport master (
      output btn_raw,
      input  btn_lvl,
      input  btn_press,
      input  btn_rpt
   );

   modport slave (
      input  btn_raw,
      output btn_lvl,
      output btn_press,
      output btn_rpt
   );
endinterface

// File: rtl/btn_chan.sv
// One pushbutton channel: 2-flop synchronizer, debounce counter,
// press edge detect and IDLE/DELAY/REPEAT auto-repeat FSM.
module btn_chan
   import clock_pkg::*;
#(
   parameter int DB_CYCLES  = DEF_DB_CYCLES,
   parameter int RPT_DELAY  = DEF_RPT_DELAY,
   parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_lvl,
   output logic btn_press,
   output logic btn_rpt
);

   localparam int CNT_W  = cnt_width(DB_CYCLES);
   localparam int RCNT_W = cnt_width(max_int(RPT_DELAY, RPT_PERIOD));

   localparam logic [CNT_W-1:0]  DB_LAST     = CNT_W'(DB_CYCLES - 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(RPT_DELAY - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(RPT_PERIOD - 1);

   logic              s1_reg, s2_reg;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              lvl_reg, lvl_next;
   logic              press_reg, press_next;
   logic              rpt_reg, rpt_next;
   rpt_state_t        state_reg, state_next;
   logic [RCNT_W-1:0] rcnt_reg, rcnt_next;

   logic pressed;
   logic rise;
   logic fall;

   // Debounce: the level only moves after DB_CYCLES consecutive samples that
   // disagree with it; any agreeing sample restarts the count.
   always_comb begin
      pressed  = ~s2_reg;
      cnt_next = '0;
      lvl_next = lvl_reg;
      if (pressed != lvl_reg) begin
         if (cnt_reg == DB_LAST) begin
            lvl_next = ~lvl_reg;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
      rise       = lvl_next & ~lvl_reg;
      fall       = ~lvl_next & lvl_reg;
      press_next = rise;
   end

   // Repeat FSM works off the next-level edges so its pulse lines up with
   // the registered press pulse.
   always_comb begin
      state_next = state_reg;
      rcnt_next  = rcnt_reg;
      rpt_next   = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (rise) begin
               state_next = DELAY;
               rcnt_next  = '0;
               rpt_next   = 1'b1;
            end
         end
         DELAY: begin
            if (fall) begin
               state_next = IDLE;
               rcnt_next  = '0;
            end else if (rcnt_reg == DELAY_LAST) begin
               state_next = REPEAT;
               rcnt_next  = '0;
               rpt_next   = 1'b1;
            end else begin
               rcnt_next = rcnt_reg + 1'b1;
            end
         end
         REPEAT: begin
            if (fall) begin
               state_next = IDLE;
               rcnt_next  = '0;
            end else if (rcnt_reg == PERIOD_LAST) begin
               rcnt_next = '0;
               rpt_next  = 1'b1;
            end else begin
               rcnt_next = rcnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            rcnt_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg    <= 1'b1;
         s2_reg    <= 1'b1;
         cnt_reg   <= '0;
         lvl_reg   <= 1'b0;
         press_reg <= 1'b0;
         rpt_reg   <= 1'b0;
         state_reg <= IDLE;
         rcnt_reg  <= '0;
      end else begin
         s1_reg    <= btn_raw;
         s2_reg    <= s1_reg;
         cnt_reg   <= cnt_next;
         lvl_reg   <= lvl_next;
         press_reg <= press_next;
         rpt_reg   <= rpt_next;
         state_reg <= state_next;
         rcnt_reg  <= rcnt_next;
      end
   end

   assign btn_lvl   = lvl_reg;
   assign btn_press = press_reg;
   assign btn_rpt   = rpt_reg;

endmodule

// File: rtl/clock_btn_cond.sv
// Pushbutton conditioner for the clock control FSM: NUM_BTN independent
// debounced channels with press and auto-repeat pulses.
module clock_btn_cond
   import clock_pkg::*;
#(
   parameter int NUM_BTN    = BTN_SET_ALARM + 1,
   parameter int DB_CYCLES  = DEF_DB_CYCLES,
   parameter int RPT_DELAY  = DEF_RPT_DELAY,
   parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
   input  logic            clk,
   input  logic            rst,
   clock_btn_cond_if.slave bus
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
         btn_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
         ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (bus.btn_raw[gi]),
            .btn_lvl   (bus.btn_lvl[gi]),
            .btn_press (bus.btn_press[gi]),
            .btn_rpt   (bus.btn_rpt[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clock_btn_cond.sv
// Self-checking bench for clock_btn_cond: directed steps plus random bounce,
// compared every cycle against a sample-history reference model.
module tb_clock_btn_cond;

   localparam int NB = 4;
   localparam int DB = 4;
   localparam int RD = 8;
   localparam int RP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   clock_btn_cond_if #(.NUM_BTN(NB)) bus ();

   clock_btn_cond #(
      .NUM_BTN    (NB),
      .DB_CYCLES  (DB),
      .RPT_DELAY  (RD),
      .RPT_PERIOD (RP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: lvl flips once the last DB synchronized samples all
   // disagree with it; repeat pulses follow from the press time arithmetically.
   logic [NB-1:0] m_lvl, m_press, m_rpt;
   bit            m_s1 [NB];
   bit            m_s2 [NB];
   bit            hist [NB][$];
   int            press_at [NB];
   int            cyc = 0;

   task automatic model_edge();
      bit seen;
      bit all_diff;
      bit prev;
      int d;
      cyc++;
      for (int c = 0; c < NB; c++) begin
         if (rst) begin
            m_s1[c] = 1'b1;
            m_s2[c] = 1'b1;
            hist[c].delete();
            m_lvl[c]   = 1'b0;
            m_press[c] = 1'b0;
            m_rpt[c]   = 1'b0;
            press_at[c] = -1;
         end else begin
            seen    = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = bus.btn_raw[c];
            hist[c].push_back(!seen);
            if (hist[c].size() > DB) void'(hist[c].pop_front());
            all_diff = (hist[c].size() == DB);
            for (int k = 0; k < hist[c].size(); k++)
               if (hist[c][k] == m_lvl[c]) all_diff = 1'b0;
            prev = m_lvl[c];
            if (all_diff) m_lvl[c] = !m_lvl[c];
            m_press[c] = m_lvl[c] && !prev;
            if (m_press[c]) press_at[c] = cyc;
            if (!m_lvl[c]) press_at[c] = -1;
            d = cyc - press_at[c];
            m_rpt[c] = m_lvl[c] && (press_at[c] >= 0) &&
                       ((d == 0) || ((d >= RD) && ((d - RD) % RP == 0)));
         end
      end
   endtask

   task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("model_lvl", bus.btn_lvl, m_lvl);
      check("model_press", bus.btn_press, m_press);
      check("model_rpt", bus.btn_rpt, m_rpt);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int  rpt_at [7];
      bit  exp_b;
      rpt_at = '{5, 13, 16, 19, 22, 25, 28};
      bus.btn_raw = 4'b0000;
      rst = 1'b1;

      // Reset held with all buttons pressed
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_lvl", bus.btn_lvl, 4'b0000);
         check("rst_press", bus.btn_press, 4'b0000);
         check("rst_rpt", bus.btn_rpt, 4'b0000);
      end
      rst = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         step();
         if (i == 4) check("post_rst_early", bus.btn_press, 4'b0000);
         if (i == 5) check("post_rst_press", bus.btn_press, 4'b1111);
         if (i == 6) check("post_rst_drop", bus.btn_press, 4'b0000);
      end
      $display("txn reset-held press: press seen 5 edges after reset release");
      bus.btn_raw = 4'b1111;
      idle(10);

      // Single clean press on set_time
      bus.btn_raw = 4'b1101;
      for (int i = 0; i <= 6; i++) begin
         step();
         if (i == 4) check("ch1_lvl_early", bus.btn_lvl, 4'b0000);
         if (i == 5) begin
            check("ch1_lvl", bus.btn_lvl, 4'b0010);
            check("ch1_press", bus.btn_press, 4'b0010);
            check("ch1_rpt", bus.btn_rpt, 4'b0010);
         end
         if (i == 6) begin
            check("ch1_press_drop", bus.btn_press, 4'b0000);
            check("ch1_rpt_drop", bus.btn_rpt, 4'b0000);
         end
      end
      $display("txn set_time press: single-cycle press/rpt pulse");
      bus.btn_raw = 4'b1111;
      idle(10);

      // Bounce on stop_watch: 0,0,0,1,0 then stable low
      for (int i = 0; i <= 10; i++) begin
         bus.btn_raw[2] = (i == 3);
         step();
         if (i < 9) check("ch2_bounce_nopulse", 4'(bus.btn_press[2]), 4'd0);
         if (i == 9) check("ch2_bounce_press", bus.btn_press, 4'b0100);
      end
      $display("txn stop_watch bounce: press 5 edges after final low sample");
      bus.btn_raw = 4'b1111;
      idle(10);

      // Held strtStp: auto-repeat schedule
      bus.btn_raw = 4'b1110;
      for (int i = 0; i < 30; i++) begin
         step();
         if (i >= 5) begin
            exp_b = 1'b0;
            for (int k = 0; k < 7; k++) if (rpt_at[k] == i) exp_b = 1'b1;
            check("ch0_rpt_sched", 4'(bus.btn_rpt[0]), 4'(exp_b));
            check("ch0_press_once", 4'(bus.btn_press[0]), 4'(i == 5));
         end
      end
      $display("txn strtStp hold: repeat at P, P+8, then every 3");

      // Release during REPEAT, then re-press
      bus.btn_raw = 4'b1111;
      for (int j = 0; j < 12; j++) begin
         step();
         if (j == 4) check("ch0_rel_lvl_hold", 4'(bus.btn_lvl[0]), 4'd1);
         if (j == 5) check("ch0_rel_lvl_fall", 4'(bus.btn_lvl[0]), 4'd0);
         if (j >= 5) check("ch0_rel_norpt", 4'(bus.btn_rpt[0]), 4'd0);
      end
      bus.btn_raw = 4'b1110;
      for (int k = 0; k < 15; k++) begin
         step();
         if (k >= 5) check("ch0_repress_rpt", 4'(bus.btn_rpt[0]), 4'((k == 5) || (k == 13)));
      end
      $display("txn strtStp release/re-press: DELAY timing restarts");
      bus.btn_raw = 4'b1111;
      idle(10);

      // Random bounce bursts on all channels, model-checked every cycle
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < 12; i++) begin
            bus.btn_raw = 4'($urandom_range(0, 15));
            step();
         end
         bus.btn_raw = 4'($urandom_range(0, 15));
         idle($urandom_range(6, 20));
         $display("txn random burst %0d: raw settled at %b", b, bus.btn_raw);
      end
      bus.btn_raw = 4'b1111;
      idle(10);

      // Simultaneous strtStp + set_alarm, reset mid-REPEAT
      bus.btn_raw = 4'b0110;
      for (int i = 0; i <= 16; i++) begin
         step();
         if (i == 5) check("ch03_same_cycle", bus.btn_press, 4'b1001);
      end
      rst = 1'b1;
      step();
      check("midrst_lvl", bus.btn_lvl, 4'b0000);
      check("midrst_press", bus.btn_press, 4'b0000);
      check("midrst_rpt", bus.btn_rpt, 4'b0000);
      step();
      bus.btn_raw = 4'b1111;
      rst = 1'b0;
      idle(8);
      $display("txn strtStp+set_alarm then mid-REPEAT reset: outputs cleared");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
